tx_arbiter: RTL

- Round-robin arbiter that shares the single serial TX controller between `NUM_REQ` bus requesters.
- Latches one request at a time and drives the controller's valid/addr/wdata/we port with a stable payload.
- Returns a per-requester done or error pulse.
- Enforces the controller's "valid must fall before the next transaction" rule and recovers from hung transactions with a watchdog.

---
 rtl/tx_arbiter_if.sv | 19 +
 rtl/tx_arbiter.sv | 143 ++++++++++++++
 2 files changed

// File: rtl/tx_arbiter_if.sv
// Shared bus widths and the arbiter <-> serial TX controller port bundle.
// Handshake: the arbiter holds valid with a stable payload until ready completes the transfer, then drops valid for one cycle.
package bus_pkg;
    localparam int ADDR_WIDTH = 16;
    localparam int DATA_WIDTH = 8;
endpackage

interface tx_arbiter_if;
    import bus_pkg::*;

    logic                  valid;
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] wdata;
    logic                  we;
    logic                  ready;

    modport master (output valid, output addr, output wdata, output we, input ready);
    modport slave  (input valid, input addr, input wdata, input we, output ready);
endinterface

// File: rtl/tx_arbiter.sv
// Round-robin arbiter sharing one serial TX controller between NUM_REQ requesters,
// with a stable registered payload, per-requester done/error pulses and a hung-transfer watchdog.
module tx_arbiter
    import bus_pkg::*;
#(
    parameter int NUM_REQ        = 2,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                                 clk_i,
    input  logic                                 rst_ni,
    input  logic [NUM_REQ-1:0]                   req_valid_i,
    input  logic [NUM_REQ-1:0][ADDR_WIDTH-1:0]   req_addr_i,
    input  logic [NUM_REQ-1:0][DATA_WIDTH-1:0]   req_wdata_i,
    input  logic [NUM_REQ-1:0]                   req_we_i,
    output logic [NUM_REQ-1:0]                   req_gnt_o,
    output logic [NUM_REQ-1:0]                   req_done_o,
    output logic [NUM_REQ-1:0]                   req_err_o,
    tx_arbiter_if.master                         tx,
    output logic                                 busy_o,
    output logic [1:0]                           dbg_state_o
);

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int CNT_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = (TIMEOUT_CYCLES > 0) ? CNT_W'(TIMEOUT_CYCLES - 1) : '0;
    localparam logic [IDX_W-1:0] LAST_RST = IDX_W'(NUM_REQ - 1);
    localparam bit WDOG_EN = (TIMEOUT_CYCLES != 0);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ISSUE   = 2'd1,
        ST_WAIT    = 2'd2,
        ST_RELEASE = 2'd3
    } state_e;

    state_e                state_q;
    logic [IDX_W-1:0]      last_q;
    logic [IDX_W-1:0]      gnt_idx_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [DATA_WIDTH-1:0] wdata_q;
    logic                  we_q;
    logic [CNT_W-1:0]      cnt_q;
    logic [NUM_REQ-1:0]    gnt_q;
    logic                  valid_q;
    logic                  busy_q;

    logic                  win_vld_d;
    logic [IDX_W-1:0]      win_idx_d;
    logic                  timeout_hit;
    logic [NUM_REQ-1:0]    owner_onehot;

    // Search starts just above the last winner, so the previous owner is considered last.
    always_comb begin : arb
        int               cand;
        logic [IDX_W-1:0] cand_idx;
        win_vld_d = 1'b0;
        win_idx_d = last_q;
        cand      = 0;
        cand_idx  = '0;
        for (int i = 1; i <= NUM_REQ; i++) begin
            cand = int'(last_q) + i;
            if (cand >= NUM_REQ) begin
                cand = cand - NUM_REQ;
            end
            cand_idx = IDX_W'(cand);
            if (!win_vld_d && req_valid_i[cand_idx]) begin
                win_vld_d = 1'b1;
                win_idx_d = cand_idx;
            end
        end
    end

    assign timeout_hit  = WDOG_EN && (cnt_q == CNT_LAST);
    assign owner_onehot = NUM_REQ'(1) << gnt_idx_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= ST_IDLE;
            last_q    <= LAST_RST;
            gnt_idx_q <= '0;
            addr_q    <= '0;
            wdata_q   <= '0;
            we_q      <= 1'b0;
            cnt_q     <= '0;
            gnt_q     <= '0;
            valid_q   <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (tx.ready && win_vld_d) begin
                        state_q   <= ST_ISSUE;
                        gnt_idx_q <= win_idx_d;
                        last_q    <= win_idx_d;
                        addr_q    <= req_addr_i[win_idx_d];
                        wdata_q   <= req_wdata_i[win_idx_d];
                        we_q      <= req_we_i[win_idx_d];
                        gnt_q     <= NUM_REQ'(1) << win_idx_d;
                        valid_q   <= 1'b1;
                        busy_q    <= 1'b1;
                    end
                end
                ST_ISSUE: begin
                    state_q <= ST_WAIT;
                    cnt_q   <= '0;
                end
                ST_WAIT: begin
                    if (cnt_q != {CNT_W{1'b1}}) begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                    if (tx.ready || timeout_hit) begin
                        state_q <= ST_RELEASE;
                        gnt_q   <= '0;
                        valid_q <= 1'b0;
                    end
                end
                ST_RELEASE: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                end
                default: begin
                    state_q <= ST_IDLE;
                    gnt_q   <= '0;
                    valid_q <= 1'b0;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    // Completion takes precedence over a watchdog abort in the same cycle.
    assign req_done_o = (state_q == ST_WAIT && tx.ready) ? owner_onehot : '0;
    assign req_err_o  = (state_q == ST_WAIT && !tx.ready && timeout_hit) ? owner_onehot : '0;

    assign req_gnt_o   = gnt_q;
    assign tx.valid    = valid_q;
    assign tx.addr     = addr_q;
    assign tx.wdata    = wdata_q;
    assign tx.we       = we_q;
    assign busy_o      = busy_q;
    assign dbg_state_o = state_q;

endmodule
